// File: rtl/axi_lite_cfg_arbiter_if.sv
// AXI-Lite bus between the configuration arbiter (master side) and the
// register-bank slave that holds the common configure registers.
interface axi_lite_cfg_arbiter_if #(
    parameter int ASIZE = 32,
    parameter int DSIZE = 32
);
    logic [ASIZE-1:0]   awaddr;
    logic               awvalid;
    logic               awready;
    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               wvalid;
    logic               wready;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;
    logic [ASIZE-1:0]   araddr;
    logic               arvalid;
    logic               arready;
    logic [DSIZE-1:0]   rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_cfg_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port between NUM local
// requesters, one outstanding transaction at a time, with a per-requester ack.
module axi_lite_cfg_arbiter #(
    parameter int NUM   = 4,
    parameter int ASIZE = 32,
    parameter int DSIZE = 32
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NUM-1:0]           req_i,
    input  logic [NUM-1:0]           req_wr_i,
    input  logic [NUM*ASIZE-1:0]     req_addr_i,
    input  logic [NUM*DSIZE-1:0]     req_wdata_i,
    output logic [NUM-1:0]           req_ack_o,
    output logic [DSIZE-1:0]         rsp_rdata_o,
    output logic [1:0]               rsp_resp_o,
    output logic                     busy_o,
    output logic [$clog2(NUM)-1:0]   grant_id_o,
    output logic [15:0]              err_cnt_o,
    axi_lite_cfg_arbiter_if.master   axi
);
    localparam int IW = $clog2(NUM);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, ACK} state_e;

    state_e             state_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      grantId_q;
    logic [ASIZE-1:0]   addr_q;
    logic [DSIZE-1:0]   wdata_q;
    logic [NUM-1:0]     ack_q;
    logic [DSIZE-1:0]   rdata_q;
    logic [1:0]         resp_q;
    logic               busy_q;
    logic [15:0]        errCnt_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic               arvalid_q;
    logic               rready_q;

    logic               pickValid_d;
    logic [IW-1:0]      pick_d;
    logic               awDone_d;
    logic               wDone_d;
    int                 cand;

    // Scan downward so the lowest rotated distance from the pointer wins.
    always_comb begin
        pickValid_d = 1'b0;
        pick_d      = '0;
        cand        = 0;
        for (int k = NUM; k >= 1; k--) begin
            cand = (int'(ptr_q) + k) % NUM;
            if (req_i[cand]) begin
                pickValid_d = 1'b1;
                pick_d      = IW'(cand);
            end
        end
    end

    assign awDone_d = !awvalid_q || axi.awready;
    assign wDone_d  = !wvalid_q  || axi.wready;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NUM - 1);
            grantId_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            errCnt_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        grantId_q <= pick_d;
                        ptr_q     <= pick_d;
                        addr_q    <= req_addr_i[pick_d*ASIZE +: ASIZE];
                        wdata_q   <= req_wdata_i[pick_d*DSIZE +: DSIZE];
                        busy_q    <= 1'b1;
                        if (req_wr_i[pick_d]) begin
                            state_q   <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RA;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
                    if (awDone_d && wDone_d) begin
                        state_q  <= WB;
                        bready_q <= 1'b1;
                    end
                end
                WB: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        resp_q   <= axi.bresp;
                        ack_q    <= NUM'(1) << grantId_q;
                        state_q  <= ACK;
                    end
                end
                RA: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD;
                    end
                end
                RD: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= axi.rdata;
                        resp_q   <= axi.rresp;
                        ack_q    <= NUM'(1) << grantId_q;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (resp_q != 2'b00 && errCnt_q != 16'hFFFF) errCnt_q <= errCnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack_o   = ack_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = grantId_q;
    assign err_cnt_o   = errCnt_q;

    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = '1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_cfg_arbiter.sv
// Self-checking bench for axi_lite_cfg_arbiter: directed timing steps plus a
// randomized phase, checked against a round-robin/transaction reference model.
module tb_axi_lite_cfg_arbiter;
    localparam int NUM   = 4;
    localparam int ASIZE = 32;
    localparam int DSIZE = 32;

    logic                 clock = 1'b0;
    logic                 rst   = 1'b1;
    logic [NUM-1:0]       req;
    logic [NUM-1:0]       reqWr;
    logic [NUM*ASIZE-1:0] reqAddr;
    logic [NUM*DSIZE-1:0] reqWdata;
    logic [NUM-1:0]       reqAck;
    logic [DSIZE-1:0]     rspRdata;
    logic [1:0]           rspResp;
    logic                 busy;
    logic [1:0]           grantId;
    logic [15:0]          errCnt;

    int          nChecks = 0;
    int          nFail   = 0;
    int          modelPtr = NUM - 1;
    logic [15:0] modelErr = '0;
    logic [31:0] modelRdata = '0;
    logic        tWr    [NUM];
    logic [31:0] tAddr  [NUM];
    logic [31:0] tWdata [NUM];

    int          awDly = 0, wDly = 0, bDly = 0, arDly = 0, rDly = 0;
    int          awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
    bit          randDly = 1'b0;
    logic [31:0] slvAwaddr = '0, slvWdata = '0, slvAraddr = '0;

    axi_lite_cfg_arbiter_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) axi ();

    axi_lite_cfg_arbiter #(.NUM(NUM), .ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .clock       (clock),
        .rst         (rst),
        .req_i       (req),
        .req_wr_i    (reqWr),
        .req_addr_i  (reqAddr),
        .req_wdata_i (reqWdata),
        .req_ack_o   (reqAck),
        .rsp_rdata_o (rspRdata),
        .rsp_resp_o  (rspResp),
        .busy_o      (busy),
        .grant_id_o  (grantId),
        .err_cnt_o   (errCnt),
        .axi         (axi.master)
    );

    always #5 clock = ~clock;

    // The register-bank slave answers from the address alone, so the model
    // can predict every response without looking at the bus.
    function automatic logic [1:0] respFor(input logic [31:0] a);
        return a[9:8];
    endfunction

    function automatic logic [31:0] rdataFor(input logic [31:0] a);
        if (a == 32'h24) return 32'h1234_5678;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int rrPick();
        int c;
        for (int k = 1; k <= NUM; k++) begin
            c = (modelPtr + k) % NUM;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        tWr[i]    = wr;
        tAddr[i]  = a;
        tWdata[i] = d;
        req[i]    = 1'b1;
        reqWr[i]  = wr;
        reqAddr[i*ASIZE +: ASIZE]  = a;
        reqWdata[i*DSIZE +: DSIZE] = d;
    endtask

    task automatic applyRandom(input int i);
        logic [31:0] a;
        a = $urandom();
        a[1:0] = 2'b00;
        applyStimulus(i, 1'($urandom_range(0, 1)), a, $urandom());
    endtask

    task automatic dropAll();
        req   = '0;
        reqWr = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        dropAll();
        repeat (2) @(negedge clock);
        rst        = 1'b0;
        modelPtr   = NUM - 1;
        modelErr   = '0;
        modelRdata = '0;
    endtask

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "_awvalid"}, 32'(axi.awvalid), 32'd0);
        checkOutput({pfx, "_wvalid"},  32'(axi.wvalid),  32'd0);
        checkOutput({pfx, "_bready"},  32'(axi.bready),  32'd0);
        checkOutput({pfx, "_arvalid"}, 32'(axi.arvalid), 32'd0);
        checkOutput({pfx, "_rready"},  32'(axi.rready),  32'd0);
        checkOutput({pfx, "_ack"},     32'(reqAck),      32'd0);
        checkOutput({pfx, "_busy"},    32'(busy),        32'd0);
    endtask

    // mode 0: drop the requester after its ack; 1: it keeps requesting;
    // 2: random renew/drop with random newcomers.
    task automatic serve(input int nAcks, input int mode, input int budget);
        int got = 0;
        int cyc = 0;
        int expG;
        expG = rrPick();
        while (got < nAcks && cyc < budget && expG >= 0) begin
            @(negedge clock);
            cyc++;
            if (reqAck != '0) begin
                checkOutput("ack_onehot", 32'(reqAck), 32'(1) << expG);
                checkOutput("grant_id", 32'(grantId), 32'(expG));
                checkOutput("busy_in_ack", 32'(busy), 32'd1);
                checkOutput("err_cnt", 32'(errCnt), 32'(modelErr));
                if (tWr[expG]) begin
                    checkOutput("slave_awaddr", slvAwaddr, tAddr[expG]);
                    checkOutput("slave_wdata", slvWdata, tWdata[expG]);
                end else begin
                    modelRdata = rdataFor(tAddr[expG]);
                end
                checkOutput("rsp_rdata", rspRdata, modelRdata);
                checkOutput("rsp_resp", 32'(rspResp), 32'(respFor(tAddr[expG])));
                if (respFor(tAddr[expG]) != 2'b00 && modelErr != 16'hFFFF) modelErr++;
                modelPtr = expG;
                got++;
                if (got >= nAcks) begin
                    dropAll();
                end else if (mode == 1) begin
                    applyRandom(expG);
                end else if (mode == 2) begin
                    if ($urandom_range(0, 1) == 1) applyRandom(expG);
                    else req[expG] = 1'b0;
                    for (int j = 0; j < NUM; j++)
                        if (!req[j] && $urandom_range(0, 3) == 0) applyRandom(j);
                    if (req == '0) applyRandom($urandom_range(0, NUM - 1));
                end else begin
                    req[expG] = 1'b0;
                end
                expG = rrPick();
            end
        end
        checkOutput("ack_count", 32'(got), 32'(nAcks));
        @(negedge clock);
        checkOutput("err_final", 32'(errCnt), 32'(modelErr));
    endtask

    // Slave model: programmable per-channel ready/valid delays, cleared by rst.
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata  = '0;   axi.rresp = '0;
        forever begin
            @(negedge clock);
            if (rst) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
                axi.arready = 1'b0; axi.rvalid = 1'b0;
                awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
            end else begin
                if (axi.awready) axi.awready = 1'b0;
                else if (axi.awvalid) begin
                    if (awCnt >= awDly) begin
                        axi.awready = 1'b1; slvAwaddr = axi.awaddr; awCnt = 0;
                        if (randDly) awDly = $urandom_range(0, 3);
                    end else awCnt++;
                end
                if (axi.wready) axi.wready = 1'b0;
                else if (axi.wvalid) begin
                    if (wCnt >= wDly) begin
                        axi.wready = 1'b1; slvWdata = axi.wdata; wCnt = 0;
                        if (randDly) wDly = $urandom_range(0, 3);
                    end else wCnt++;
                end
                if (axi.bvalid) axi.bvalid = 1'b0;
                else if (axi.bready) begin
                    if (bCnt >= bDly) begin
                        axi.bvalid = 1'b1; axi.bresp = respFor(slvAwaddr); bCnt = 0;
                        if (randDly) bDly = $urandom_range(0, 3);
                    end else bCnt++;
                end
                if (axi.arready) axi.arready = 1'b0;
                else if (axi.arvalid) begin
                    if (arCnt >= arDly) begin
                        axi.arready = 1'b1; slvAraddr = axi.araddr; arCnt = 0;
                        if (randDly) arDly = $urandom_range(0, 3);
                    end else arCnt++;
                end
                if (axi.rvalid) axi.rvalid = 1'b0;
                else if (axi.rready) begin
                    if (rCnt >= rDly) begin
                        axi.rvalid = 1'b1; axi.rdata = rdataFor(slvAraddr);
                        axi.rresp = respFor(slvAraddr); rCnt = 0;
                        if (randDly) rDly = $urandom_range(0, 3);
                    end else rCnt++;
                end
            end
        end
    end

    initial begin
        logic [4:0] awPat;
        logic [4:0] wPat;
        logic [4:0] bPat;
        req = '0; reqWr = '0; reqAddr = '0; reqWdata = '0;

        // Reset values while rst is held.
        repeat (2) @(negedge clock);
        checkIdleOutputs("reset");
        checkOutput("reset_grant_id", 32'(grantId), 32'd0);
        checkOutput("reset_err_cnt", 32'(errCnt), 32'd0);
        checkOutput("reset_rdata", rspRdata, 32'd0);
        checkOutput("reset_resp", 32'(rspResp), 32'd0);
        rst = 1'b0;

        // Single zero-wait write: valids at T1, bready at T2, ack at T3.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clock);
        checkOutput("t1_awvalid", 32'(axi.awvalid), 32'd1);
        checkOutput("t1_wvalid", 32'(axi.wvalid), 32'd1);
        checkOutput("t1_awaddr", axi.awaddr, 32'h10);
        checkOutput("t1_wdata", axi.wdata, 32'hDEAD_BEEF);
        checkOutput("t1_wstrb", 32'(axi.wstrb), 32'hF);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("t2_bready", 32'(axi.bready), 32'd1);
        checkOutput("t2_awvalid", 32'(axi.awvalid), 32'd0);
        serve(1, 0, 1);
        checkOutput("after_ack_busy", 32'(busy), 32'd0);
        checkOutput("after_ack_ack", 32'(reqAck), 32'd0);

        // Read with a slow slave.
        arDly = 3; rDly = 2;
        applyStimulus(2, 1'b0, 32'h24, 32'h0);
        serve(1, 0, 20);
        arDly = 0; rDly = 0;

        // Skewed write handshakes: wready at T1, awready at T4.
        awDly = 3; wDly = 0;
        awPat = 5'b01111; wPat = 5'b00001; bPat = 5'b10000;
        applyStimulus(1, 1'b1, 32'h40, 32'hCAFE_F00D);
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            checkOutput($sformatf("skew_awvalid_t%0d", t + 1), 32'(axi.awvalid), 32'(awPat[t]));
            checkOutput($sformatf("skew_wvalid_t%0d", t + 1), 32'(axi.wvalid), 32'(wPat[t]));
            checkOutput($sformatf("skew_bready_t%0d", t + 1), 32'(axi.bready), 32'(bPat[t]));
        end
        serve(1, 0, 3);
        awDly = 0;

        // Round-robin with all four requesters held: 0,1,2,3,0,1.
        doReset();
        for (int i = 0; i < NUM; i++) applyRandom(i);
        serve(6, 1, 300);

        // Error responses: three write errors and one read error.
        doReset();
        applyStimulus(1, 1'b1, 32'h200, 32'h1111_1111);
        serve(1, 0, 50);
        applyStimulus(2, 1'b1, 32'h204, 32'h2222_2222);
        serve(1, 0, 50);
        applyStimulus(3, 1'b1, 32'h208, 32'h3333_3333);
        serve(1, 0, 50);
        applyStimulus(0, 1'b0, 32'h300, 32'h0);
        serve(1, 0, 50);
        checkOutput("err_four", 32'(errCnt), 32'd4);
        force dut.errCnt_q = 16'hFFFF;
        @(negedge clock);
        release dut.errCnt_q;
        modelErr = 16'hFFFF;
        checkOutput("err_forced", 32'(errCnt), 32'hFFFF);
        applyStimulus(2, 1'b1, 32'h20C, 32'h4444_4444);
        serve(1, 0, 50);
        checkOutput("err_saturated", 32'(errCnt), 32'hFFFF);

        // Reset while waiting in RD, then requester 0 must beat requester 1.
        rDly = 8;
        applyStimulus(3, 1'b0, 32'h80, 32'h0);
        repeat (2) @(negedge clock);
        checkOutput("in_rd_rready", 32'(axi.rready), 32'd1);
        rst = 1'b1;
        dropAll();
        @(negedge clock);
        checkIdleOutputs("midrst");
        checkOutput("midrst_err_cnt", 32'(errCnt), 32'd0);
        checkOutput("midrst_rdata", rspRdata, 32'd0);
        checkOutput("midrst_grant_id", 32'(grantId), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        modelPtr = NUM - 1; modelErr = '0; modelRdata = '0;
        rDly = 0;
        applyStimulus(1, 1'b1, 32'h54, 32'h5555_AAAA);
        applyStimulus(0, 1'b0, 32'h58, 32'h0);
        serve(2, 0, 50);

        // Randomized traffic with random slave delays.
        randDly = 1'b1;
        applyRandom(0);
        applyRandom(2);
        serve(40, 2, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/axi_lite_cfg_arbiter.md
Name: axi_lite_cfg_arbiter

Overview:
- Shares one AXI-Lite master port between NUM local requesters: CPU bridge, init sequencer, debug port.
- The port drives the register-bank slave that exposes common_configure_reg_interface registers.
- Round-robin grant; one outstanding transaction at a time.
- Per-requester one-cycle ack returns rdata/resp; saturating count of non-OKAY responses.

Parameters:
NUM, 4, number of requesters (2..16)
ASIZE, 32, address width
DSIZE, 32, data width

Ports:
clock  in  1  single clock domain
rst  in  1  synchronous reset, active-high
req  in  NUM  per-requester request; held high with fields stable until own ack
req_wr  in  NUM  1 = write, 0 = read
req_addr  in  NUM*ASIZE  requester i at bits [i*ASIZE +: ASIZE]
req_wdata  in  NUM*DSIZE  requester i at bits [i*DSIZE +: DSIZE]
req_ack  out  NUM  one-hot, one-cycle completion pulse
rsp_rdata  out  DSIZE  read data, valid in ack cycle
rsp_resp  out  2  bresp/rresp of completed transaction, valid in ack cycle
busy  out  1  high from grant until ack inclusive
grant_id  out  $clog2(NUM)  index of current/last granted requester
err_cnt  out  16  saturating count of responses != 2'b00
axi_awaddr/awvalid/awready  out/out/in  ASIZE/1/1  AW channel
axi_wdata/wvalid/wready  out/out/in  DSIZE/1/1  W channel
axi_wstrb  out  DSIZE/8  constant all ones
axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
axi_araddr/arvalid/arready  out/out/in  ASIZE/1/1  AR channel
axi_rdata/rresp/rvalid/rready  in/in/in/out  DSIZE/2/1/1  R channel

Behaviour:
- Reset (rst sampled high at posedge):
  - state IDLE; all valid/ready/ack outputs 0; rsp_rdata 0, rsp_resp 0, busy 0, err_cnt 0.
  - rr pointer = NUM-1, so requester 0 wins first; grant_id 0.
- Reset mid-transaction aborts immediately; the slave must be reset together.
- All outputs are registered.
- States: IDLE, WR, WB, RA, RD, ACK.
- IDLE:
  - If any req bit set, grant the first set bit searching (ptr+1) mod NUM upward with wrap.
  - Latch index, wr, addr, wdata; set ptr = grant index.
  - Next state WR if wr else RA. busy=1 from next cycle.
- WR:
  - awvalid and wvalid both rise on entry.
  - Each drops independently the cycle after its own valid&ready.
  - When both handshakes are done (same or different cycles) -> WB; bready=1 on entry.
- WB: on bvalid&bready -> ACK; latch bresp into rsp_resp; bready drops.
- RA: arvalid=1 until arvalid&arready -> RD; rready=1 on entry.
- RD: on rvalid&rready -> ACK; latch rdata to rsp_rdata and rresp to rsp_resp; rready drops.
- ACK (one cycle):
  - req_ack[grant]=1; busy=1.
  - err_cnt += 1 if rsp_resp != 0, saturating at 16'hFFFF.
  - Next state IDLE.
- rsp_rdata holds its last value after a write transaction (unchanged).
- IDLE samples req in the cycle after ACK:
  - A requester that still holds req then starts a new transaction.
  - Round-robin still applies, so it yields to other pending requesters.
- Minimum latency, zero-wait slave (T0 = IDLE grant cycle):
  - write: valids at T1, bready at T2, ack at T3.
  - read: arvalid at T1, rready at T2, ack at T3.
- Arbitration is evaluated only in IDLE. Changes on req during a transaction do not affect the granted transaction.
- Addresses and data are driven from latched copies, never combinationally from req_* inputs.
- No timeout: the FSM waits indefinitely for the slave.

Test Plan:
- Single write, zero-wait slave: req[0], wr=1, addr 0x10, wdata 0xDEADBEEF → awvalid/wvalid at T1, awaddr 0x10, wdata 0xDEADBEEF, req_ack=4'b0001 at T3, rsp_resp 0.
- Read with delayed slave: req[2] read addr 0x24; arready after 3 cycles; rvalid 2 cycles later with rdata 0x12345678 → rsp_rdata 0x12345678 in ack cycle, req_ack=4'b0100, grant_id 2.
- Skewed write handshakes: wready at T1, awready at T4 → wvalid low from T2, awvalid low from T5, bready from T5, ack after bvalid.
- Round-robin fairness: all four req held continuously → grant order 0,1,2,3,0,1; each ack one-hot in that order; no requester served twice consecutively.
- Error responses: 3 writes with bresp 2'b10 and 1 read with rresp 2'b11 → err_cnt 4, rsp_resp matches each response; err_cnt preloaded via force to 16'hFFFF stays 16'hFFFF after another error.
- Reset mid-read: assert rst while in RD → next cycle all valids/readies/acks 0, state IDLE; after release, the first request from requester 0 is granted before requester 1 when both are pending.
